// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer text dump path: ASCII constants,
// dumper FSM state encoding and the nibble-to-hex-character helper.
package la_pkg;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] HASH = 8'h23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_EMIT,
        S_NEXT,
        S_FIN
    } state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/la_hex_ascii.sv
// Purpose: 4-bit value to uppercase ASCII hex character ('0'-'9', 'A'-'F').
// Latency: combinational. Backpressure: none.
module la_hex_ascii
    import la_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_ascii(nib);

endmodule

// File: rtl/la_uart_dumper.sv
// Purpose: streams N samples from capture RAM as uppercase hex + CR LF into uart_tx6.
// Latency: RAM read + 1 cycle to first byte; one idle cycle between bytes. Backpressure: stalls on tx_full.
// Optional: LA_DUMP_HEADER_EN prepends "#" + 4-digit hex sample count + CR LF.
module la_uart_dumper
    import la_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     sample_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [SAMPLE_W-1:0] mem_data,
    output logic [7:0]          tx_data,
    output logic                tx_write,
    input  logic                tx_full
);

    localparam int              DIGITS   = SAMPLE_W / 4;
    localparam logic [7:0]      CR_IDX   = 8'(DIGITS);
    localparam logic [7:0]      LF_IDX   = 8'(DIGITS + 1);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     remaining;
    logic [SAMPLE_W-1:0] sh;
    logic [SAMPLE_W-1:0] sh_nx;
    logic [7:0]          idx;
    logic [7:0]          nxt_idx;
    logic [7:0]          nxt_byte;
    logic [7:0]          hex_byte;
    logic [3:0]          nib;
    logic                wr_pend;
    logic                fire;
    logic                last_byte;

`ifdef LA_DUMP_HEADER_EN
    logic        hdr;
    logic [19:0] hdr_sh;
    logic [19:0] hdr_nx;
    assign hdr_nx = hdr_sh << 4;
`endif

    // The strobe is gated by the live full flag so a byte is never offered to a full FIFO.
    assign fire     = wr_pend & ~tx_full;
    assign tx_write = fire;
    assign sh_nx    = sh << 4;
    assign nxt_idx  = idx + 8'd1;

    always_comb begin
        nib = sh_nx[SAMPLE_W-1 -: 4];
        if (state == S_LATCH) begin
            nib = mem_data[SAMPLE_W-1 -: 4];
        end
`ifdef LA_DUMP_HEADER_EN
        else if (hdr) begin
            nib = hdr_nx[19:16];
        end
`endif
    end

    la_hex_ascii u_hex (
        .nib   (nib),
        .ascii (hex_byte)
    );

    always_comb begin
        if (nxt_idx < CR_IDX)       nxt_byte = hex_byte;
        else if (nxt_idx == CR_IDX) nxt_byte = CR;
        else                        nxt_byte = LF;
        last_byte = (idx == LF_IDX);
`ifdef LA_DUMP_HEADER_EN
        if (hdr) begin
            if (nxt_idx < 8'd5)       nxt_byte = hex_byte;
            else if (nxt_idx == 8'd5) nxt_byte = CR;
            else                      nxt_byte = LF;
            last_byte = (idx == 8'd6);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            tx_data   <= 8'h00;
            wr_pend   <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            sh        <= '0;
            idx       <= '0;
`ifdef LA_DUMP_HEADER_EN
            hdr       <= 1'b0;
            hdr_sh    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (sample_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            cur_addr  <= start_addr;
                            remaining <= sample_count;
`ifdef LA_DUMP_HEADER_EN
                            hdr       <= 1'b1;
                            hdr_sh    <= {4'h0, 16'(sample_count)};
                            idx       <= '0;
                            tx_data   <= HASH;
                            wr_pend   <= 1'b1;
                            state     <= S_EMIT;
`else
                            mem_rd    <= 1'b1;
                            mem_addr  <= start_addr;
                            state     <= S_RD;
`endif
                        end
                    end
                end
                S_RD: begin
                    mem_rd <= 1'b0;
                    state  <= S_LATCH;
                end
                S_LATCH: begin
                    sh      <= mem_data;
                    idx     <= '0;
                    tx_data <= hex_byte;
                    wr_pend <= 1'b1;
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (fire) begin
                        wr_pend <= 1'b0;
                        if (last_byte) begin
`ifdef LA_DUMP_HEADER_EN
                            if (hdr) begin
                                hdr      <= 1'b0;
                                mem_rd   <= 1'b1;
                                mem_addr <= cur_addr;
                                state    <= S_RD;
                            end else
`endif
                            state <= S_NEXT;
                        end else begin
                            idx     <= nxt_idx;
                            sh      <= sh_nx;
                            tx_data <= nxt_byte;
`ifdef LA_DUMP_HEADER_EN
                            hdr_sh  <= hdr_nx;
`endif
                        end
                    end else if (!wr_pend) begin
                        // Idle gap after a write has elapsed; offer the next byte.
                        wr_pend <= 1'b1;
                    end
                end
                S_NEXT: begin
                    remaining <= remaining - CNT_ONE;
                    cur_addr  <= cur_addr + ADDR_ONE;
                    if (remaining == CNT_ONE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= cur_addr + ADDR_ONE;
                        state    <= S_RD;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A byte strobed in the abort cycle still goes out; nothing follows it.
            if (abort && busy) begin
                state   <= S_FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
                wr_pend <= 1'b0;
                mem_rd  <= 1'b0;
`ifdef LA_DUMP_HEADER_EN
                hdr     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_la_uart_dumper.sv
// Directed bench for la_uart_dumper: byte streams, address wrap, full-flag stall,
// abort, zero count, start-while-busy and mid-dump reset.
module tb_la_uart_dumper;

    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 16;
`ifdef LA_DUMP_HEADER_EN
    localparam int HDR_LEN = 7;
`else
    localparam int HDR_LEN = 0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [ADDR_W:0]     sample_count = '0;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [SAMPLE_W-1:0] mem_data;
    logic [7:0]          tx_data;
    logic                tx_write;
    logic                tx_full = 1'b0;

    la_uart_dumper #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .start_addr   (start_addr),
        .sample_count (sample_count),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .tx_data      (tx_data),
        .tx_write     (tx_write),
        .tx_full      (tx_full)
    );

    always #5 clk = ~clk;

    logic [SAMPLE_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [SAMPLE_W-1:0] mem_q = '0;
    always @(posedge clk) if (mem_rd) mem_q <= ram[mem_addr];
    assign mem_data = mem_q;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          rd_addrs[$];
    int          done_cnt = 0;
    int          full_viol = 0;
    int          b2b_viol = 0;
    int          busy_cnt = 0;
    logic        prev_wr = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (tx_write) begin
            got.push_back(tx_data);
            if (tx_full) full_viol++;
            if (prev_wr) b2b_viol++;
        end
        prev_wr = tx_write;
        if (mem_rd) rd_addrs.push_back(int'(mem_addr));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] c);
        start_addr   = a;
        sample_count = c;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        start_addr   = ~a;
        sample_count = 11'd5;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_bytes(input string tag, input int nbytes, input int budget);
        int n;
        n = 0;
        while (got.size() < nbytes && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic exp_t1();
        exp_q.delete();
`ifdef LA_DUMP_HEADER_EN
        add_str("#0003");
`endif
        add_str("0000");
        add_str("BEEF");
        add_str("1234");
    endtask

    initial begin
        int d0;
        int fv0;
        int bv0;
        int b0;
        int sz;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h5A5A;
        ram[5]    = 16'h0000;
        ram[6]    = 16'hBEEF;
        ram[7]    = 16'h1234;
        ram[1023] = 16'hFFFF;
        ram[0]    = 16'h0001;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_tx_write", 32'(tx_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        tick();

        // Three samples from address 5
        got.delete();
        exp_t1();
        d0 = done_cnt; fv0 = full_viol; bv0 = b2b_viol;
        pulse_start(10'd5, 11'd3);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done("t1", 600);
        compare_stream("t1");
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_b2b", 32'(b2b_viol - bv0), 32'd0);
        check("t1_full", 32'(full_viol - fv0), 32'd0);

        // Address wrap 1023 -> 0
        got.delete();
        rd_addrs.delete();
        exp_q.delete();
`ifdef LA_DUMP_HEADER_EN
        add_str("#0002");
`endif
        add_str("FFFF");
        add_str("0001");
        pulse_start(10'd1023, 11'd2);
        wait_done("t2", 600);
        compare_stream("t2");
        check("t2_rd_count", rd_addrs.size(), 32'd2);
        check("t2_rd_addr0", (rd_addrs.size() > 0) ? rd_addrs[0] : -1, 32'd1023);
        check("t2_rd_addr1", (rd_addrs.size() > 1) ? rd_addrs[1] : -1, 32'd0);

        // Full flag held for 200 cycles mid-sample
        got.delete();
        exp_t1();
        d0 = done_cnt; fv0 = full_viol; bv0 = b2b_viol;
        pulse_start(10'd5, 11'd3);
        wait_bytes("t3_pre", HDR_LEN + 2, 600);
        tx_full = 1'b1;
        sz = got.size();
        for (int i = 0; i < 200; i++) tick();
        check("t3_no_write_while_full", got.size(), sz);
        check("t3_busy_while_full", 32'(busy), 32'd1);
        tx_full = 1'b0;
        wait_done("t3", 600);
        compare_stream("t3");
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t3_full", 32'(full_viol - fv0), 32'd0);
        check("t3_b2b", 32'(b2b_viol - bv0), 32'd0);

        // Abort after the second byte of sample 1
        got.delete();
        d0 = done_cnt;
        pulse_start(10'd5, 11'd4);
        wait_bytes("t4_pre", HDR_LEN + 2, 600);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t4_bytes", got.size(), 32'(HDR_LEN + 2));
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // Normal start after abort
        got.delete();
        exp_q.delete();
`ifdef LA_DUMP_HEADER_EN
        add_str("#0001");
`endif
        add_str("BEEF");
        pulse_start(10'd6, 11'd1);
        wait_done("t4b", 600);
        compare_stream("t4b");

        // Zero count
        got.delete();
        d0 = done_cnt;
        b0 = busy_cnt;
        pulse_start(10'd5, 11'd0);
        check("t5_done_next", 32'(done), 32'd1);
        tick();
        check("t5_done_width", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t5_writes", got.size(), 32'd0);
        check("t5_busy_never", 32'(busy_cnt - b0), 32'd0);

        // Start while busy is ignored
        got.delete();
        exp_t1();
        d0 = done_cnt;
        pulse_start(10'd5, 11'd3);
        for (int i = 0; i < 10; i++) tick();
        pulse_start(10'd6, 11'd1);
        wait_done("t5b", 600);
        for (int i = 0; i < 20; i++) tick();
        compare_stream("t5b");
        check("t5b_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset mid-dump
        got.delete();
        pulse_start(10'd5, 11'd3);
        wait_bytes("t6_pre", HDR_LEN + 3, 600);
        reset = 1'b0;
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_mem_rd", 32'(mem_rd), 32'd0);
        check("t6_tx_write", 32'(tx_write), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        sz = got.size();
        for (int i = 0; i < 50; i++) tick();
        check("t6_no_more_writes", got.size(), sz);
        check("t6_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
